pb_sample_fifo_irq: RTL and testbench

- Responder-side peripheral on the PicoBlaze (pacoblaze3) I/O port bus.
- Buffers 8-bit samples from the audio/volume datapath in a 16-entry FIFO.
- The processor reads samples and status through input ports and configures the block through output ports.
- Raises the processor interrupt when the FIFO fill level reaches a programmable threshold, and drops it on interrupt_ack.

---
 rtl/pb_sample_fifo_irq.sv | 209 ++++++++++++++++++++
 tb/tb_pb_sample_fifo_irq.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_sample_fifo_irq.sv
// pb_sample_fifo_irq
// PicoBlaze I/O-port responder that queues 8-bit datapath samples in a
// 16-entry FIFO. The processor pops samples and reads status/count through
// input ports, and configures interrupt enable, flush, overflow clear and
// the fill threshold through output ports. The interrupt fires once each
// time the fill level climbs to the threshold. It re-arms only after the
// level drops below the threshold again.

module pb_sample_fifo_irq #(
   parameter logic [7:0] DATA_PORT   = 8'h00,
   parameter logic [7:0] STATUS_PORT = 8'h01,
   parameter logic [7:0] COUNT_PORT  = 8'h02,
   parameter logic [7:0] CTRL_PORT   = 8'h04,
   parameter logic [7:0] THRESH_PORT = 8'h08
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] sample_data,
   input  logic       sample_valid,
   input  logic [7:0] port_id,
   input  logic       read_strobe,
   input  logic       write_strobe,
   input  logic [7:0] out_port,
   output logic [7:0] in_port,
   output logic       interrupt,
   input  logic       interrupt_ack,
   output logic [4:0] fifo_count
);

   localparam logic [4:0] DEPTH      = 5'd16;
   localparam logic [4:0] THRESH_RST = 5'd8;

   // Storage and state registers
   logic [7:0] mem_r [0:15];
   logic [3:0] rd_ptr_r;
   logic [3:0] wr_ptr_r;
   logic [4:0] count_r;
   logic [7:0] in_port_r;
   logic       interrupt_r;
   logic       armed_r;
   logic       irq_en_r;
   logic       overflow_r;
   logic [4:0] threshold_r;

   // Combinational decode
   logic       empty_s;
   logic       full_s;
   logic       ctrl_wr_s;
   logic       thresh_wr_s;
   logic       flush_s;
   logic       ovf_clr_s;
   logic       pop_s;
   logic       push_s;
   logic       ovf_set_s;
   logic [4:0] next_count_s;
   logic [4:0] thresh_clamp_s;
   logic       irq_set_s;
   logic [7:0] status_s;
   logic [7:0] rd_mux_s;

   // Port decode, FIFO handshake, next fill level and read-data mux
   always_comb begin
      empty_s        = 1'b0;
      full_s         = 1'b0;
      ctrl_wr_s      = 1'b0;
      thresh_wr_s    = 1'b0;
      flush_s        = 1'b0;
      ovf_clr_s      = 1'b0;
      pop_s          = 1'b0;
      push_s         = 1'b0;
      ovf_set_s      = 1'b0;
      next_count_s   = count_r;
      thresh_clamp_s = threshold_r;
      irq_set_s      = 1'b0;
      status_s       = 8'h00;
      rd_mux_s       = 8'h00;

      empty_s     = (count_r == 5'd0);
      full_s      = (count_r == DEPTH);
      ctrl_wr_s   = write_strobe && (port_id == CTRL_PORT);
      thresh_wr_s = write_strobe && (port_id == THRESH_PORT);
      flush_s     = ctrl_wr_s && out_port[1];
      ovf_clr_s   = ctrl_wr_s && out_port[2];

      // A flush wins over any pop or push happening on the same edge.
      pop_s     = read_strobe && (port_id == DATA_PORT) && !empty_s && !flush_s;
      // When full, a simultaneous pop frees the slot the push needs.
      push_s    = sample_valid && (!full_s || pop_s) && !flush_s;
      ovf_set_s = sample_valid && full_s && !pop_s && !flush_s;

      if (flush_s) begin
         next_count_s = 5'd0;
      end else begin
         case ({push_s, pop_s})
            2'b10:   next_count_s = count_r + 5'd1;
            2'b01:   next_count_s = count_r - 5'd1;
            default: next_count_s = count_r;
         endcase
      end

      if (out_port == 8'h00) begin
         thresh_clamp_s = 5'd1;
      end else if (out_port > 8'd16) begin
         thresh_clamp_s = DEPTH;
      end else begin
         thresh_clamp_s = out_port[4:0];
      end

      irq_set_s = irq_en_r && armed_r && (next_count_s >= threshold_r);

      status_s = {3'b000, irq_en_r, interrupt_r, overflow_r, full_s, empty_s};

      case (port_id)
         DATA_PORT: begin
            if (empty_s) begin
               rd_mux_s = 8'h00;
            end else begin
               rd_mux_s = mem_r[rd_ptr_r];
            end
         end
         STATUS_PORT: rd_mux_s = status_s;
         COUNT_PORT:  rd_mux_s = {3'b000, count_r};
         default:     rd_mux_s = 8'h00;
      endcase
   end

   // Sample storage; contents need no reset because the pointers define validity
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= sample_data;
      end
   end

   // Read/write pointers and fill count
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_r <= 4'd0;
         wr_ptr_r <= 4'd0;
         count_r  <= 5'd0;
      end else if (flush_s) begin
         rd_ptr_r <= 4'd0;
         wr_ptr_r <= 4'd0;
         count_r  <= 5'd0;
      end else begin
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + 4'd1;
         end
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + 4'd1;
         end
         count_r <= next_count_s;
      end
   end

   // Control register, sticky overflow flag and interrupt threshold
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_en_r    <= 1'b0;
         overflow_r  <= 1'b0;
         threshold_r <= THRESH_RST;
      end else begin
         if (ctrl_wr_s) begin
            irq_en_r <= out_port[0];
         end
         if (ovf_clr_s) begin
            overflow_r <= 1'b0;
         end else if (ovf_set_s) begin
            overflow_r <= 1'b1;
         end
         if (thresh_wr_s) begin
            threshold_r <= thresh_clamp_s;
         end
      end
   end

   // Edge-style interrupt: fire once at threshold, re-arm below it, ack wins
   always_ff @(posedge clk) begin
      if (reset) begin
         interrupt_r <= 1'b0;
         armed_r     <= 1'b1;
      end else begin
         if (next_count_s < threshold_r) begin
            armed_r <= 1'b1;
         end else if (irq_set_s) begin
            armed_r <= 1'b0;
         end

         if (interrupt_ack) begin
            interrupt_r <= 1'b0;
         end else if (irq_set_s) begin
            interrupt_r <= 1'b1;
         end
      end
   end

   // Pipelined read-data register, follows port_id every cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         in_port_r <= 8'h00;
      end else begin
         in_port_r <= rd_mux_s;
      end
   end

   assign in_port    = in_port_r;
   assign interrupt  = interrupt_r;
   assign fifo_count = count_r;

endmodule

// File: tb/tb_pb_sample_fifo_irq.sv
// Self-checking bench for pb_sample_fifo_irq: a vector table for port
// decode and threshold behaviour, then directed sequences with a sample
// scoreboard queue for FIFO ordering, overflow, flush and interrupt cases.

module tb_pb_sample_fifo_irq;

   localparam logic [7:0] DATA_P   = 8'h00;
   localparam logic [7:0] STATUS_P = 8'h01;
   localparam logic [7:0] COUNT_P  = 8'h02;
   localparam logic [7:0] CTRL_P   = 8'h04;
   localparam logic [7:0] THRESH_P = 8'h08;
   localparam logic [7:0] IDLE_P   = 8'h10;

   logic       clk;
   logic       reset;
   logic [7:0] sample_data;
   logic       sample_valid;
   logic [7:0] port_id;
   logic       read_strobe;
   logic       write_strobe;
   logic [7:0] out_port;
   logic [7:0] in_port;
   logic       interrupt;
   logic       interrupt_ack;
   logic [4:0] fifo_count;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] sb_q[$];

   typedef struct {
      logic [7:0] pid;
      logic       rs;
      logic       ws;
      logic [7:0] op;
      logic       sv;
      logic [7:0] sd;
      logic       ack;
      logic [7:0] exp_in;
      logic [4:0] exp_cnt;
      logic       exp_irq;
   } vec_t;

   vec_t tbl[16];

   pb_sample_fifo_irq dut (
      .clk           (clk),
      .reset         (reset),
      .sample_data   (sample_data),
      .sample_valid  (sample_valid),
      .port_id       (port_id),
      .read_strobe   (read_strobe),
      .write_strobe  (write_strobe),
      .out_port      (out_port),
      .in_port       (in_port),
      .interrupt     (interrupt),
      .interrupt_ack (interrupt_ack),
      .fifo_count    (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      sb_q.delete();
   endtask

   task automatic push_sample(input logic [7:0] d);
      sample_valid = 1'b1;
      sample_data  = d;
      if (sb_q.size() < 16) sb_q.push_back(d);
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic write_port(input logic [7:0] id, input logic [7:0] v);
      port_id      = id;
      out_port     = v;
      write_strobe = 1'b1;
      tick();
      write_strobe = 1'b0;
      port_id      = IDLE_P;
   endtask

   task automatic expect_port(input logic [7:0] id, input logic [7:0] exp, input string name);
      port_id = id;
      tick();
      port_id = IDLE_P;
      check(name, in_port, exp);
   endtask

   task automatic read_data(input string name);
      logic [7:0] exp;
      port_id     = DATA_P;
      read_strobe = 1'b1;
      tick();
      read_strobe = 1'b0;
      port_id     = IDLE_P;
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'h00;
      check(name, in_port, exp);
   endtask

   // Pop and push on the same edge; used while full
   task automatic read_push(input logic [7:0] d, input string name);
      logic [7:0] exp;
      port_id      = DATA_P;
      read_strobe  = 1'b1;
      sample_valid = 1'b1;
      sample_data  = d;
      tick();
      read_strobe  = 1'b0;
      sample_valid = 1'b0;
      port_id      = IDLE_P;
      exp = sb_q.pop_front();
      sb_q.push_back(d);
      check(name, in_port, exp);
   endtask

   task automatic ack_pulse;
      interrupt_ack = 1'b1;
      tick();
      interrupt_ack = 1'b0;
   endtask

   initial begin
      //            pid     rs    ws    op     sv    sd     ack   exp_in exp_cnt exp_irq
      tbl[0]  = '{STATUS_P, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h01, 5'd0, 1'b0};
      tbl[1]  = '{COUNT_P,  1'b0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 8'h00, 5'd1, 1'b0};
      tbl[2]  = '{COUNT_P,  1'b0, 1'b0, 8'h00, 1'b1, 8'h6B, 1'b0, 8'h01, 5'd2, 1'b0};
      tbl[3]  = '{DATA_P,   1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h5A, 5'd2, 1'b0};
      tbl[4]  = '{8'h03,    1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 5'd2, 1'b0};
      tbl[5]  = '{8'h80,    1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 5'd2, 1'b0};
      tbl[6]  = '{8'h05,    1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 8'h00, 5'd2, 1'b0};
      tbl[7]  = '{STATUS_P, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 5'd2, 1'b0};
      tbl[8]  = '{CTRL_P,   1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 8'h00, 5'd2, 1'b0};
      tbl[9]  = '{STATUS_P, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h10, 5'd2, 1'b0};
      tbl[10] = '{DATA_P,   1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h5A, 5'd1, 1'b0};
      tbl[11] = '{THRESH_P, 1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 8'h00, 5'd1, 1'b0};
      tbl[12] = '{STATUS_P, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h10, 5'd1, 1'b1};
      tbl[13] = '{STATUS_P, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h18, 5'd1, 1'b1};
      tbl[14] = '{STATUS_P, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h18, 5'd1, 1'b0};
      tbl[15] = '{COUNT_P,  1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h01, 5'd1, 1'b0};

      reset         = 1'b1;
      sample_data   = 8'h00;
      sample_valid  = 1'b0;
      port_id       = IDLE_P;
      read_strobe   = 1'b0;
      write_strobe  = 1'b0;
      out_port      = 8'h00;
      interrupt_ack = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      check("rst_in_port", in_port, 8'h00);
      check("rst_count", fifo_count, 5'd0);
      check("rst_irq", interrupt, 1'b0);

      // Vector table: port decode, exact match, threshold lowering
      for (int i = 0; i < 16; i++) begin
         port_id       = tbl[i].pid;
         read_strobe   = tbl[i].rs;
         write_strobe  = tbl[i].ws;
         out_port      = tbl[i].op;
         sample_valid  = tbl[i].sv;
         sample_data   = tbl[i].sd;
         interrupt_ack = tbl[i].ack;
         tick();
         check($sformatf("vec%0d_in_port", i), in_port, tbl[i].exp_in);
         check($sformatf("vec%0d_count", i), fifo_count, tbl[i].exp_cnt);
         check($sformatf("vec%0d_irq", i), interrupt, tbl[i].exp_irq);
      end
      read_strobe   = 1'b0;
      write_strobe  = 1'b0;
      sample_valid  = 1'b0;
      interrupt_ack = 1'b0;
      port_id       = IDLE_P;

      // Ordering, pop on empty, status when empty
      do_reset();
      push_sample(8'h11);
      push_sample(8'h22);
      push_sample(8'h33);
      read_data("fifo_rd1");
      read_data("fifo_rd2");
      read_data("fifo_rd3");
      read_data("rd_empty");
      check("rd_empty_count", fifo_count, 5'd0);
      expect_port(STATUS_P, 8'h01, "status_empty");

      // Fill plus one: overflow, drop of 17th sample, overflow clear
      for (int i = 0; i < 17; i++) push_sample(i[7:0]);
      check("full_count", fifo_count, 5'd16);
      expect_port(STATUS_P, 8'h06, "status_full_ovf");
      expect_port(DATA_P, sb_q[0], "head_peek");
      write_port(CTRL_P, 8'h04);
      expect_port(STATUS_P, 8'h02, "status_ovf_clr");

      // Push and pop together while full, then drain via scoreboard
      read_push(8'hAA, "full_rdpush");
      check("full_rdpush_count", fifo_count, 5'd16);
      expect_port(STATUS_P, 8'h02, "full_rdpush_status");
      for (int i = 0; i < 16; i++) read_data($sformatf("drain%0d", i));
      check("drain_count", fifo_count, 5'd0);

      // Threshold 4 interrupt, ack, no re-fire, re-arm below threshold
      write_port(CTRL_P, 8'h01);
      write_port(THRESH_P, 8'h04);
      push_sample(8'hA1);
      push_sample(8'hA2);
      push_sample(8'hA3);
      check("th4_below", interrupt, 1'b0);
      push_sample(8'hA4);
      check("th4_rise", interrupt, 1'b1);
      ack_pulse();
      check("th4_ack", interrupt, 1'b0);
      push_sample(8'hA5);
      tick();
      check("th4_no_refire", interrupt, 1'b0);
      read_data("th4_rd1");
      read_data("th4_rd2");
      check("th4_count3", fifo_count, 5'd3);
      check("th4_still_low", interrupt, 1'b0);
      push_sample(8'hA6);
      check("th4_rearm", interrupt, 1'b1);
      ack_pulse();

      // Threshold clamp: 0 acts as 1, 0xFF acts as 16
      write_port(CTRL_P, 8'h03);
      sb_q.delete();
      check("flush_count", fifo_count, 5'd0);
      write_port(THRESH_P, 8'h00);
      tick();
      check("th1_idle", interrupt, 1'b0);
      push_sample(8'hB0);
      check("th1_rise", interrupt, 1'b1);
      ack_pulse();
      write_port(THRESH_P, 8'hFF);
      tick();
      check("th16_after_wr", interrupt, 1'b0);
      for (int i = 0; i < 14; i++) push_sample(8'hC0 + i[7:0]);
      check("th16_count15", fifo_count, 5'd15);
      check("th16_low", interrupt, 1'b0);
      push_sample(8'hCF);
      check("th16_rise", interrupt, 1'b1);
      ack_pulse();

      // Flush with 10 stored and a concurrent push, then reset mid-stream
      write_port(CTRL_P, 8'h03);
      sb_q.delete();
      for (int i = 0; i < 10; i++) push_sample(8'hD0 + i[7:0]);
      check("ten_count", fifo_count, 5'd10);
      sample_valid = 1'b1;
      sample_data  = 8'hEE;
      write_port(CTRL_P, 8'h03);
      sample_valid = 1'b0;
      sb_q.delete();
      check("flush10_count", fifo_count, 5'd0);
      expect_port(STATUS_P, 8'h11, "flush10_status");
      write_port(THRESH_P, 8'h02);
      push_sample(8'h01);
      push_sample(8'h02);
      push_sample(8'h03);
      check("pre_reset_irq", interrupt, 1'b1);
      port_id      = STATUS_P;
      sample_valid = 1'b1;
      sample_data  = 8'h77;
      reset        = 1'b1;
      tick();
      sample_valid = 1'b0;
      tick();
      reset = 1'b0;
      sb_q.delete();
      check("mid_rst_in_port", in_port, 8'h00);
      check("mid_rst_irq", interrupt, 1'b0);
      check("mid_rst_count", fifo_count, 5'd0);
      expect_port(STATUS_P, 8'h01, "mid_rst_status");
      read_data("mid_rst_empty_rd");
      write_port(CTRL_P, 8'h01);
      for (int i = 0; i < 7; i++) push_sample(8'h40 + i[7:0]);
      check("th8_count7", interrupt, 1'b0);
      push_sample(8'h47);
      check("th8_rise", interrupt, 1'b1);
      check("th8_count", fifo_count, 5'd8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
